// File: rtl/alu_pkg.sv
// Operation codes shared by the EX-stage operand logic and the ALU, plus the
// decoder's aluop encodings and the R-type funct values the ALU control understands.
package alu_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_RSVD  = 2'b11;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;

endpackage

// File: rtl/alu_control.sv
// Combinational decode of the pipelined aluop/funct pair into the ALU operation code.
module alu_control
    import alu_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [3:0] operation
);

    always_comb begin
        operation = OP_ADD;
        case (aluop)
            ALUOP_ADD:  operation = OP_ADD;
            ALUOP_SUB:  operation = OP_SUB;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD: operation = OP_ADD;
                    FUNCT_SUB: operation = OP_SUB;
                    FUNCT_AND: operation = OP_AND;
                    FUNCT_OR:  operation = OP_OR;
                    FUNCT_SLT: operation = OP_SLT;
                    FUNCT_NOR: operation = OP_NOR;
                    default:   operation = OP_ADD;
                endcase
            end
            // Reserved encoding behaves like add so a stray decode stays harmless.
            ALUOP_RSVD: operation = OP_ADD;
            default:    operation = OP_ADD;
        endcase
    end

endmodule

// File: rtl/idex_operand_stage.sv
// ID/EX pipeline register with EX-stage forwarding, operand-B selection and ALU control.
// Outputs feed the ALU operation/data_a/data_b inputs directly.
module idex_operand_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int RADDR = 5
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [1:0]       id_aluop,
    input  logic [5:0]       id_funct,
    input  logic             id_alusrc,
    input  logic             id_regwrite,
    input  logic [RADDR-1:0] id_rs,
    input  logic [RADDR-1:0] id_rt,
    input  logic [RADDR-1:0] id_rd,
    input  logic [WIDTH-1:0] id_rs_val,
    input  logic [WIDTH-1:0] id_rt_val,
    input  logic [WIDTH-1:0] id_imm,
    input  logic             exmem_regwrite,
    input  logic [RADDR-1:0] exmem_rd,
    input  logic [WIDTH-1:0] exmem_result,
    input  logic             memwb_regwrite,
    input  logic [RADDR-1:0] memwb_rd,
    input  logic [WIDTH-1:0] memwb_result,
    output logic [3:0]       operation,
    output logic [WIDTH-1:0] data_a,
    output logic [WIDTH-1:0] data_b,
    output logic [WIDTH-1:0] store_data,
    output logic             ex_valid,
    output logic             ex_regwrite,
    output logic [RADDR-1:0] ex_rd
);

    logic             valid_q;
    logic             regwrite_q;
    logic [1:0]       aluop_q;
    logic [5:0]       funct_q;
    logic             alusrc_q;
    logic [RADDR-1:0] rs_q;
    logic [RADDR-1:0] rt_q;
    logic [RADDR-1:0] rd_q;
    logic [WIDTH-1:0] rs_val_q;
    logic [WIDTH-1:0] rt_val_q;
    logic [WIDTH-1:0] imm_q;

    // Pipeline control: flush loads an all-zero bubble and outranks stall;
    // stall freezes every field; otherwise the decode slot is captured each edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset || flush) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            aluop_q    <= 2'b00;
            funct_q    <= 6'd0;
            alusrc_q   <= 1'b0;
            rs_q       <= '0;
            rt_q       <= '0;
            rd_q       <= '0;
            rs_val_q   <= '0;
            rt_val_q   <= '0;
            imm_q      <= '0;
        end else if (!stall) begin
            valid_q    <= id_valid;
            regwrite_q <= id_regwrite;
            aluop_q    <= id_aluop;
            funct_q    <= id_funct;
            alusrc_q   <= id_alusrc;
            rs_q       <= id_rs;
            rt_q       <= id_rt;
            rd_q       <= id_rd;
            rs_val_q   <= id_rs_val;
            rt_val_q   <= id_rt_val;
            imm_q      <= id_imm;
        end
    end

    // The nearer producer (EX/MEM) wins; $0 is never forwarded.
    function automatic logic [WIDTH-1:0] forward_operand(
        input logic [RADDR-1:0] src,
        input logic [WIDTH-1:0] rf_val,
        input logic             em_we,
        input logic [RADDR-1:0] em_rd,
        input logic [WIDTH-1:0] em_val,
        input logic             mw_we,
        input logic [RADDR-1:0] mw_rd,
        input logic [WIDTH-1:0] mw_val
    );
        if (em_we && (em_rd != '0) && (em_rd == src))
            return em_val;
        else if (mw_we && (mw_rd != '0) && (mw_rd == src))
            return mw_val;
        else
            return rf_val;
    endfunction

    logic [WIDTH-1:0] fwd_a;
    logic [WIDTH-1:0] fwd_b;

    always_comb begin
        fwd_a = forward_operand(rs_q, rs_val_q, exmem_regwrite, exmem_rd, exmem_result,
                                memwb_regwrite, memwb_rd, memwb_result);
        fwd_b = forward_operand(rt_q, rt_val_q, exmem_regwrite, exmem_rd, exmem_result,
                                memwb_regwrite, memwb_rd, memwb_result);
    end

    assign data_a      = fwd_a;
    assign data_b      = alusrc_q ? imm_q : fwd_b;
    assign store_data  = fwd_b;
    assign ex_valid    = valid_q;
    assign ex_regwrite = regwrite_q & valid_q;
    assign ex_rd       = rd_q;

    alu_control u_alu_control (
        .aluop     (aluop_q),
        .funct     (funct_q),
        .operation (operation)
    );

endmodule

// File: tb/tb_idex_operand_stage.sv
// Directed bench for idex_operand_stage: reset, capture, forwarding priority, $0,
// immediate select, ALU control decode, flush-over-stall and stall hold.
module tb_idex_operand_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        id_valid;
    logic [1:0]  id_aluop;
    logic [5:0]  id_funct;
    logic        id_alusrc;
    logic        id_regwrite;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic [31:0] id_rs_val;
    logic [31:0] id_rt_val;
    logic [31:0] id_imm;
    logic        exmem_regwrite;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_result;
    logic        memwb_regwrite;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_result;
    logic [3:0]  operation;
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic [31:0] store_data;
    logic        ex_valid;
    logic        ex_regwrite;
    logic [4:0]  ex_rd;

    int compared   = 0;
    int mismatched = 0;

    logic [5:0] fn_tab  [7] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                6'b101010, 6'b100111, 6'b001000};
    logic [3:0] op_tab  [7] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001,
                                4'b0111, 4'b1100, 4'b0010};

    idex_operand_stage #(.WIDTH(32), .RADDR(5)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .flush          (flush),
        .id_valid       (id_valid),
        .id_aluop       (id_aluop),
        .id_funct       (id_funct),
        .id_alusrc      (id_alusrc),
        .id_regwrite    (id_regwrite),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_rd          (id_rd),
        .id_rs_val      (id_rs_val),
        .id_rt_val      (id_rt_val),
        .id_imm         (id_imm),
        .exmem_regwrite (exmem_regwrite),
        .exmem_rd       (exmem_rd),
        .exmem_result   (exmem_result),
        .memwb_regwrite (memwb_regwrite),
        .memwb_rd       (memwb_rd),
        .memwb_result   (memwb_result),
        .operation      (operation),
        .data_a         (data_a),
        .data_b         (data_b),
        .store_data     (store_data),
        .ex_valid       (ex_valid),
        .ex_regwrite    (ex_regwrite),
        .ex_rd          (ex_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        stall = 0; flush = 0;
        id_valid = 0; id_aluop = 2'b00; id_funct = 6'd0; id_alusrc = 0; id_regwrite = 0;
        id_rs = 0; id_rt = 0; id_rd = 0; id_rs_val = 0; id_rt_val = 0; id_imm = 0;
        exmem_regwrite = 0; exmem_rd = 0; exmem_result = 0;
        memwb_regwrite = 0; memwb_rd = 0; memwb_result = 0;
    endtask

    task automatic load_instr(input logic [1:0] aluop, input logic [5:0] funct,
                              input logic [4:0] rs, input logic [31:0] rs_val,
                              input logic [4:0] rt, input logic [31:0] rt_val,
                              input logic [4:0] rd);
        id_valid = 1; id_regwrite = 1; id_alusrc = 0;
        id_aluop = aluop; id_funct = funct;
        id_rs = rs; id_rs_val = rs_val; id_rt = rt; id_rt_val = rt_val; id_rd = rd;
    endtask

    initial begin
        clear_inputs();
        reset = 1;
        tick();
        tick();
        check("reset_valid",     {31'd0, ex_valid},    32'd0);
        check("reset_regwrite",  {31'd0, ex_regwrite}, 32'd0);
        check("reset_rd",        {27'd0, ex_rd},       32'd0);
        check("reset_operation", {28'd0, operation},   32'h2);
        check("reset_data_a",    data_a,               32'd0);
        check("reset_data_b",    data_b,               32'd0);
        check("reset_store",     store_data,           32'd0);
        reset = 0;

        // Plain R-type sub, no hazards
        load_instr(2'b10, 6'b100010, 5'd3, 32'h10, 5'd4, 32'h20, 5'd7);
        tick();
        check("sub_operation", {28'd0, operation},   32'h6);
        check("sub_data_a",    data_a,               32'h10);
        check("sub_data_b",    data_b,               32'h20);
        check("sub_store",     store_data,           32'h20);
        check("sub_valid",     {31'd0, ex_valid},    32'd1);
        check("sub_regwrite",  {31'd0, ex_regwrite}, 32'd1);
        check("sub_rd",        {27'd0, ex_rd},       32'd7);

        // R-type funct decode, including an unlisted funct
        for (int i = 0; i < 7; i++) begin
            id_funct = fn_tab[i];
            tick();
            check($sformatf("rtype_op_%0d", i), {28'd0, operation}, {28'd0, op_tab[i]});
        end
        id_aluop = 2'b00; tick();
        check("aluop00_op", {28'd0, operation}, 32'h2);
        id_aluop = 2'b01; tick();
        check("aluop01_op", {28'd0, operation}, 32'h6);
        id_aluop = 2'b11; id_funct = 6'b100010; tick();
        check("aluop11_op", {28'd0, operation}, 32'h2);

        // Forwarding priority on rs
        load_instr(2'b10, 6'b100000, 5'd5, 32'h01, 5'd4, 32'h20, 5'd8);
        exmem_regwrite = 1; exmem_rd = 5'd5; exmem_result = 32'hAA;
        memwb_regwrite = 1; memwb_rd = 5'd5; memwb_result = 32'hBB;
        tick();
        check("fwd_exmem_a", data_a, 32'hAA);
        check("fwd_b_untouched", data_b, 32'h20);
        exmem_regwrite = 0; #1;
        check("fwd_memwb_a", data_a, 32'hBB);
        memwb_regwrite = 0; #1;
        check("fwd_none_a", data_a, 32'h01);

        // $0 never forwarded
        load_instr(2'b00, 6'd0, 5'd1, 32'h7, 5'd0, 32'h0, 5'd9);
        exmem_regwrite = 1; exmem_rd = 5'd0; exmem_result = 32'hDEAD;
        memwb_regwrite = 1; memwb_rd = 5'd0; memwb_result = 32'hBEEF;
        tick();
        check("zero_no_fwd_b", data_b, 32'h0);
        check("zero_no_fwd_a", data_a, 32'h7);

        // Immediate select with forwarded store data
        load_instr(2'b00, 6'd0, 5'd2, 32'h100, 5'd6, 32'h11, 5'd0);
        id_alusrc = 1; id_imm = 32'hFFFFFFFC; id_regwrite = 0;
        exmem_regwrite = 1; exmem_rd = 5'd6; exmem_result = 32'h55;
        memwb_regwrite = 1; memwb_rd = 5'd2; memwb_result = 32'h300;
        tick();
        check("imm_data_b",    data_b,               32'hFFFFFFFC);
        check("imm_store",     store_data,           32'h55);
        check("imm_data_a",    data_a,               32'h300);
        check("imm_regwrite",  {31'd0, ex_regwrite}, 32'd0);
        exmem_regwrite = 0; memwb_regwrite = 0;

        // Flush beats stall
        load_instr(2'b10, 6'b100101, 5'd3, 32'h33, 5'd4, 32'h44, 5'd12);
        tick();
        check("pre_flush_rd", {27'd0, ex_rd}, 32'd12);
        stall = 1; flush = 1;
        tick();
        check("flush_valid",     {31'd0, ex_valid},    32'd0);
        check("flush_regwrite",  {31'd0, ex_regwrite}, 32'd0);
        check("flush_rd",        {27'd0, ex_rd},       32'd0);
        check("flush_operation", {28'd0, operation},   32'h2);
        check("flush_data_a",    data_a,               32'd0);
        check("flush_store",     store_data,           32'd0);
        stall = 0; flush = 0;

        // Stall holds for three cycles while decode inputs change
        load_instr(2'b10, 6'b100100, 5'd8, 32'h1234, 5'd9, 32'h5678, 5'd10);
        tick();
        stall = 1;
        load_instr(2'b01, 6'd0, 5'd1, 32'hFFFF, 5'd2, 32'hEEEE, 5'd2);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("stall_a_%0d", i),  data_a, 32'h1234);
            check($sformatf("stall_b_%0d", i),  data_b, 32'h5678);
            check($sformatf("stall_op_%0d", i), {28'd0, operation}, 32'h0);
            check($sformatf("stall_rd_%0d", i), {27'd0, ex_rd}, 32'd10);
        end
        stall = 0;
        tick();
        check("unstall_rd", {27'd0, ex_rd}, 32'd2);
        check("unstall_op", {28'd0, operation}, 32'h6);
        check("unstall_a",  data_a, 32'hFFFF);

        // Asynchronous reset between edges
        load_instr(2'b10, 6'b101010, 5'd11, 32'hABCD, 5'd12, 32'h9, 5'd13);
        tick();
        check("pre_reset_op", {28'd0, operation}, 32'h7);
        #2;
        reset = 1;
        #1;
        check("async_reset_valid", {31'd0, ex_valid},  32'd0);
        check("async_reset_op",    {28'd0, operation}, 32'h2);
        check("async_reset_a",     data_a,             32'd0);
        check("async_reset_b",     data_b,             32'd0);
        tick();
        reset = 0;
        clear_inputs();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
